// File: rtl/cone_seu_err_monitor.sv
// cone_seu_err_monitor
//   Clocked golden-vs-faulty cone comparator for SEE campaigns. Over a window
//   of win_len valid samples it counts mismatching samples (err_cnt), per
//   channel mismatches (readable via rd_ch/rd_cnt), keeps a sticky mismatch
//   mask and the index of the first mismatching sample. All counters saturate.
//
//   Ports: clk, rst (async, active high), start/win_len (campaign kick-off),
//          in_valid/gold/dut (sample stream), rd_ch -> rd_cnt (count readout),
//          busy/done (status), err_any/err_mask/err_cnt/first_err_idx/
//          first_err_vld (statistics).
//   Optional: define SEE_INJECT_EN to add inj/inj_ch, which flip dut[inj_ch]
//          on an accepted sample to emulate an SEU for self-test.
//
//   Latency: a sample presented in cycle t shows up in the statistics in t+2
//   (stage 1 register, stage 2 compare/update). DRAIN covers the extra stage,
//   so done rises in the same cycle the last sample's stats become visible.

// Per-channel saturating mismatch counter.
module cone_seu_ch_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     cnt_q <= '0;
    else if (clr_i)              cnt_q <= '0;
    else if (inc_i && ~&cnt_q)   cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

module cone_seu_err_monitor #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 16,
  parameter int WIN_W = 20,
  localparam int RD_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIN_W-1:0] win_len,
  input  logic             in_valid,
  input  logic [N_CH-1:0]  gold,
  input  logic [N_CH-1:0]  dut,
  input  logic [RD_W-1:0]  rd_ch,
`ifdef SEE_INJECT_EN
  input  logic             inj,
  input  logic [RD_W-1:0]  inj_ch,
`endif
  output logic             busy,
  output logic             done,
  output logic             err_any,
  output logic [N_CH-1:0]  err_mask,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [WIN_W-1:0] first_err_idx,
  output logic             first_err_vld
);
  localparam logic [WIN_W-1:0] WIN_ONE = 'd1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_len_q, idx_q;
  logic             clr, take;

  // FSM: clr marks an accepted start, take an accepted sample
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    take    = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        clr     = 1'b1;
        state_d = (win_len != '0) ? RUN : DONE;
      end
      RUN: if (in_valid) begin
        take = 1'b1;
        if (idx_q == win_len_q - WIN_ONE) state_d = DRAIN;
      end
      DRAIN:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      win_len_q <= '0;
      idx_q     <= '0;
    end else begin
      state_q <= state_d;
      if (clr) begin
        win_len_q <= win_len;
        idx_q     <= '0;
      end else if (take) begin
        idx_q <= idx_q + WIN_ONE;
      end
    end
  end

  // Optional SEU emulation: flips one dut bit of an accepted sample
  logic [N_CH-1:0] inj_mask;
`ifdef SEE_INJECT_EN
  always_comb begin
    inj_mask = '0;
    for (int i = 0; i < N_CH; i++)
      inj_mask[i] = inj && (32'(inj_ch) == 32'(i));
  end
`else
  assign inj_mask = '0;
`endif

  // Stage 1: register the sample pair; vld_pipe_q gates everything downstream
  logic             vld_pipe_q;
  logic [N_CH-1:0]  s1_gold_q, s1_dut_q;
  logic [WIN_W-1:0] s1_idx_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= 1'b0;
      s1_gold_q  <= '0;
      s1_dut_q   <= '0;
      s1_idx_q   <= '0;
    end else begin
      vld_pipe_q <= take;
      s1_gold_q  <= gold;
      s1_dut_q   <= dut ^ inj_mask;
      s1_idx_q   <= idx_q;
    end
  end

  // Stage 2: compare and update statistics
  logic [N_CH-1:0]  diff;
  logic             hit;
  logic [CNT_W-1:0] err_cnt_q;
  logic [N_CH-1:0]  err_mask_q;
  logic [WIN_W-1:0] first_idx_q;
  logic             first_vld_q;

  assign diff = s1_gold_q ^ s1_dut_q;
  assign hit  = vld_pipe_q && (diff != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q   <= '0;
      err_mask_q  <= '0;
      first_idx_q <= '0;
      first_vld_q <= 1'b0;
    end else if (clr) begin
      err_cnt_q   <= '0;
      err_mask_q  <= '0;
      first_idx_q <= '0;
      first_vld_q <= 1'b0;
    end else if (hit) begin
      if (~&err_cnt_q) err_cnt_q <= err_cnt_q + 1'b1;
      err_mask_q <= err_mask_q | diff;
      if (!first_vld_q) begin
        first_idx_q <= s1_idx_q;
        first_vld_q <= 1'b1;
      end
    end
  end

  logic [N_CH-1:0][CNT_W-1:0] ch_cnt;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    cone_seu_ch_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (clr),
      .inc_i (vld_pipe_q && diff[g]),
      .cnt_o (ch_cnt[g])
    );
  end

  assign rd_cnt        = (32'(rd_ch) < 32'(N_CH)) ? ch_cnt[rd_ch] : '0;
  assign busy          = (state_q == RUN) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign err_cnt       = err_cnt_q;
  assign err_mask      = err_mask_q;
  // the mask is sticky, so any set bit means a mismatch was seen
  assign err_any       = |err_mask_q;
  assign first_err_idx = first_idx_q;
  assign first_err_vld = first_vld_q;
endmodule

// File: tb/tb_cone_seu_err_monitor.sv
// Bench for cone_seu_err_monitor. Small CNT_W so saturation is reachable.
module tb_cone_seu_err_monitor;
  localparam int N_CH  = 8;
  localparam int CNT_W = 4;
  localparam int WIN_W = 20;
  localparam logic [CNT_W-1:0] SAT = '1;

  logic             clk = 1'b0;
  logic             rst, start, in_valid;
  logic [WIN_W-1:0] win_len;
  logic [7:0]       gold, dut;
  logic [2:0]       rd_ch;
`ifdef SEE_INJECT_EN
  logic             inj;
  logic [2:0]       inj_ch;
`endif
  logic             busy, done, err_any, first_err_vld;
  logic [7:0]       err_mask;
  logic [CNT_W-1:0] err_cnt, rd_cnt;
  logic [WIN_W-1:0] first_err_idx;

  cone_seu_err_monitor #(.N_CH(N_CH), .CNT_W(CNT_W), .WIN_W(WIN_W)) dut_i (
    .clk(clk), .rst(rst), .start(start), .win_len(win_len),
    .in_valid(in_valid), .gold(gold), .dut(dut), .rd_ch(rd_ch),
`ifdef SEE_INJECT_EN
    .inj(inj), .inj_ch(inj_ch),
`endif
    .busy(busy), .done(done), .err_any(err_any), .err_mask(err_mask),
    .err_cnt(err_cnt), .rd_cnt(rd_cnt), .first_err_idx(first_err_idx),
    .first_err_vld(first_err_vld)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [CNT_W-1:0]           cnt;
    logic [7:0]                 mask;
    logic                       fv;
    logic [WIN_W-1:0]           fi;
    logic [N_CH-1:0][CNT_W-1:0] ch;
  } exp_t;

  exp_t       sb[$];
  exp_t       m;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] gs[64], ds[64];
  int         inj_at = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model of one accepted sample
  task automatic model_sample(input int idx, input logic [7:0] d);
    if (d != 8'h00) begin
      if (m.cnt != SAT) m.cnt = m.cnt + 1'b1;
      m.mask = m.mask | d;
      if (!m.fv) begin m.fv = 1'b1; m.fi = WIN_W'(idx); end
      for (int i = 0; i < N_CH; i++)
        if (d[i] && m.ch[i] != SAT) m.ch[i] = m.ch[i] + 1'b1;
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s sb: observed empty scoreboard expected entry", tag);
      return;
    end
    e = sb.pop_front();
    chk({tag, " done"},    32'(done), 32'd1);
    chk({tag, " busy"},    32'(busy), 32'd0);
    chk({tag, " err_cnt"}, 32'(err_cnt), 32'(e.cnt));
    chk({tag, " mask"},    32'(err_mask), 32'(e.mask));
    chk({tag, " any"},     32'(err_any), 32'(|e.mask));
    chk({tag, " fvld"},    32'(first_err_vld), 32'(e.fv));
    if (e.fv) chk({tag, " fidx"}, 32'(first_err_idx), 32'(e.fi));
    for (int i = 0; i < N_CH; i++) begin
      rd_ch = 3'(i);
      #1;
      chk($sformatf("%s ch%0d", tag, i), 32'(rd_cnt), 32'(e.ch[i]));
    end
    rd_ch = 3'd0;
  endtask

  // start a window, drive n samples (optional idle gap / stray start),
  // then wait for done and score the result
  task automatic run_win(input string tag, input int wl, input int n,
                         input int gap_at, input int restart_at);
    int cyc;
    @(negedge clk);
    start = 1'b1; win_len = WIN_W'(wl); in_valid = 1'b0;
    m = '0;
    for (int k = 0; k < n; k++) begin
      if (k == gap_at) begin
        @(negedge clk); start = 1'b0; in_valid = 1'b0;
      end
      @(negedge clk);
      start = (k == restart_at);
      if (k == restart_at) win_len = WIN_W'(10);
      in_valid = 1'b1; gold = gs[k]; dut = ds[k];
`ifdef SEE_INJECT_EN
      inj = (k == inj_at); inj_ch = 3'd3;
      if (k < wl) model_sample(k, gs[k] ^ ds[k] ^ ((k == inj_at) ? 8'h08 : 8'h00));
`else
      if (k < wl) model_sample(k, gs[k] ^ ds[k]);
`endif
    end
    sb.push_back(m);
    cyc = 0;
    do begin
      @(negedge clk);
      start = 1'b0; in_valid = 1'b0;
`ifdef SEE_INJECT_EN
      inj = 1'b0;
`endif
      cyc++;
    end while (!done && cyc < 40);
    if (n == wl) chk({tag, " latency"}, 32'(cyc), 32'd2);
    compare(tag);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; win_len = '0;
    gold = '0; dut = '0; rd_ch = '0;
`ifdef SEE_INJECT_EN
    inj = 1'b0; inj_ch = '0;
`endif
    #5;
    chk("rst done", 32'(done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst cnt",  32'(err_cnt), 32'd0);
    @(negedge clk); rst = 1'b0;

    // reset mid-RUN with err_cnt = 5
    @(negedge clk); start = 1'b1; win_len = WIN_W'(10);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); start = 1'b0; in_valid = 1'b1; gold = 8'h01; dut = 8'h00;
    end
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    chk("pre-rst cnt",  32'(err_cnt), 32'd5);
    chk("pre-rst busy", 32'(busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    chk("async cnt",  32'(err_cnt), 32'd0);
    chk("async mask", 32'(err_mask), 32'd0);
    chk("async any",  32'(err_any), 32'd0);
    chk("async fvld", 32'(first_err_vld), 32'd0);
    chk("async fidx", 32'(first_err_idx), 32'd0);
    chk("async busy", 32'(busy), 32'd0);
    chk("async done", 32'(done), 32'd0);
    chk("async ch0",  32'(rd_cnt), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("post-rst done", 32'(done), 32'd0);
    chk("post-rst busy", 32'(busy), 32'd0);

    // clean window
    for (int k = 0; k < 4; k++) begin gs[k] = 8'hA5; ds[k] = 8'hA5; end
    run_win("clean", 4, 4, -1, -1);

    // three samples with an idle cycle inside the window
    gs[0] = 8'h00; ds[0] = 8'h00;
    gs[1] = 8'h0F; ds[1] = 8'h0E;
    gs[2] = 8'hFF; ds[2] = 8'h7E;
    run_win("mix", 3, 3, 1, -1);

    // saturation
    for (int k = 0; k < 20; k++) begin gs[k] = 8'h01; ds[k] = 8'h00; end
    run_win("sat", 20, 20, -1, -1);

    // zero-length window: DONE next cycle, stats cleared, no busy
    @(negedge clk); start = 1'b1; win_len = '0;
    chk("wl0 busy before", 32'(busy), 32'd0);
    @(negedge clk); start = 1'b0;
    chk("wl0 done", 32'(done), 32'd1);
    chk("wl0 busy", 32'(busy), 32'd0);
    chk("wl0 cnt",  32'(err_cnt), 32'd0);
    chk("wl0 mask", 32'(err_mask), 32'd0);
    chk("wl0 fvld", 32'(first_err_vld), 32'd0);

    // start during RUN is ignored
    gs[0] = 8'h03; ds[0] = 8'h00;
    gs[1] = 8'h10; ds[1] = 8'h10;
    gs[2] = 8'h00; ds[2] = 8'h44;
    run_win("restart", 3, 3, -1, 1);

    // random data, extra samples after the window must be ignored
    for (int k = 0; k < 8; k++) begin
      gs[k] = 8'($urandom); ds[k] = 8'($urandom);
    end
    run_win("rand", 6, 8, -1, -1);

`ifdef SEE_INJECT_EN
    for (int k = 0; k < 5; k++) begin gs[k] = 8'h5A; ds[k] = 8'h5A; end
    inj_at = 2;
    run_win("inj", 5, 5, -1, -1);
    inj_at = -1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
